// File: rtl/task_ops_pkg.sv
// Shared task-control op bus definitions: opcodes, status codes, op-word layout, FSM states.
// Imported by the issuer and by the per-node task-control blocks.
package task_ops_pkg;

   localparam logic [3:0] OPC_NOP      = 4'h0;
   localparam logic [3:0] OPC_RDY      = 4'h1;
   localparam logic [3:0] OPC_SUSP     = 4'h2;
   localparam logic [3:0] OPC_WAIT     = 4'h3;
   localparam logic [3:0] OPC_KILL     = 4'h4;
   localparam logic [3:0] OPC_PRIO     = 4'h5;
   localparam logic [3:0] OPC_EXEHIT   = 4'h6;
   localparam logic [3:0] OPC_EXEC     = 4'h7;
   localparam logic [3:0] OPC_KILL_ALL = 4'hC;
   localparam logic [3:0] OPC_CONFIRM  = 4'hF;

   localparam logic [1:0] STAT_OK       = 2'b00;
   localparam logic [1:0] STAT_TIMEOUT  = 2'b01;
   localparam logic [1:0] STAT_REJECTED = 2'b10;

   localparam int OP_WIDTH    = 16;
   localparam int OP_ARG_LSB  = 0;
   localparam int OP_OPC_LSB  = 4;
   localparam int OP_TASK_LSB = 8;
   localparam int CMD_WIDTH   = 13;

   typedef enum logic [2:0] {
      STATE_IDLE,
      STATE_DRIVE,
      STATE_GAP,
      STATE_CHECK,
      STATE_RESP,
      STATE_REJECT
   } state_e;

   typedef struct packed {
      logic       node;
      logic [3:0] task_id;
      logic [3:0] opcode;
      logic [3:0] arg;
   } cmd_t;

   function automatic logic opcode_legal(input logic [3:0] opc);
      case (opc)
         OPC_RDY, OPC_SUSP, OPC_WAIT, OPC_KILL, OPC_PRIO,
         OPC_EXEHIT, OPC_EXEC, OPC_KILL_ALL, OPC_CONFIRM: return 1'b1;
         default:                                         return 1'b0;
      endcase
   endfunction

   // State-changing opcodes are confirmed through the sorter readback.
   function automatic logic needs_check(input logic [3:0] opc);
      case (opc)
         OPC_RDY, OPC_SUSP, OPC_WAIT, OPC_KILL, OPC_EXEC, OPC_KILL_ALL: return 1'b1;
         default:                                                       return 1'b0;
      endcase
   endfunction

   function automatic logic expects_ready(input logic [3:0] opc);
      return (opc == OPC_RDY) || (opc == OPC_EXEC);
   endfunction

   function automatic logic [OP_WIDTH-1:0] make_op_word(input cmd_t c);
      return (OP_WIDTH'(c.task_id) << OP_TASK_LSB) |
             (OP_WIDTH'(c.opcode)  << OP_OPC_LSB)  |
             (OP_WIDTH'(c.arg)     << OP_ARG_LSB);
   endfunction

endpackage

// File: rtl/op_cmd_fifo.sv
// Command queue between scheduler and issuer FSM: {node,task,opcode,arg} entries.
// Push is refused when full, even if a pop happens in the same cycle.
module op_cmd_fifo
   import task_ops_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = CMD_WIDTH
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_data = mem[rd_ptr[AW-1:0]];

   // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: storage is not reset; the pointers alone define which entries are valid.
   always_ff @(posedge CLK) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/task_op_issuer.sv
// Initiator of the task-control op bus: pops queued commands, drives op words to node0/1,
// confirms state changes via the sorter readback and reports OK/TIMEOUT/REJECTED.
module task_op_issuer
   import task_ops_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int HOLD_CYCLES = 2,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_node,
   input  logic [3:0]  cmd_task_id,
   input  logic [3:0]  cmd_opcode,
   input  logic [3:0]  cmd_arg,
   output logic [15:0] out_op_node0,
   output logic [15:0] out_op_node1,
   input  logic [7:0]  in_sorter_node0,
   input  logic [7:0]  in_sorter_node1,
   output logic        rsp_valid,
   output logic        rsp_node,
   output logic [1:0]  rsp_status,
   output logic        busy
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);

   state_e           state, state_next;
   logic [HW-1:0]    hold_cnt;
   logic [TW-1:0]    to_cnt;
   logic             cur_node;
   logic [3:0]       cur_opcode;
   logic [1:0]       killed;
   logic             fifo_full, fifo_empty, pop;
   logic [CMD_WIDTH-1:0] fifo_q;
   cmd_t             head, cmd_in;
   logic [15:0]      head_word;
   logic             head_killed, sorter_match;
   logic [7:0]       sorter_sel;
   logic [1:0]       status_next;

   assign cmd_in    = '{node: cmd_node, task_id: cmd_task_id, opcode: cmd_opcode, arg: cmd_arg};
   assign cmd_ready = !fifo_full;
   assign head      = cmd_t'(fifo_q);
   assign head_word = make_op_word(head);
   assign busy      = (state != STATE_IDLE) || !fifo_empty;

   op_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CMD_WIDTH)) u_fifo (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .push      (cmd_valid),
      .push_data (cmd_in),
      .pop       (pop),
      .pop_data  (fifo_q),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign head_killed = (head.opcode == OPC_KILL_ALL) ? |killed : killed[head.node];
   assign sorter_sel  = cur_node ? in_sorter_node1 : in_sorter_node0;

   always_comb begin
      sorter_match = 1'b0;
      if (cur_opcode == OPC_KILL_ALL)
         sorter_match = (in_sorter_node0 == 8'h00) && (in_sorter_node1 == 8'h00);
      else if (expects_ready(cur_opcode))
         sorter_match = (sorter_sel != 8'h00);
      else
         sorter_match = (sorter_sel == 8'h00);
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_next  = state;
      pop         = 1'b0;
      status_next = STAT_OK;
      case (state)
         STATE_IDLE: begin
            if (!fifo_empty) begin
               pop = 1'b1;
               if (!opcode_legal(head.opcode) || head_killed) begin
                  state_next  = STATE_REJECT;
                  status_next = STAT_REJECTED;
               end else begin
                  state_next = STATE_DRIVE;
               end
            end
         end
         STATE_DRIVE:  if (hold_cnt == HW'(HOLD_CYCLES)) state_next = STATE_GAP;
         STATE_GAP:    state_next = needs_check(cur_opcode) ? STATE_CHECK : STATE_RESP;
         STATE_CHECK: begin
            if (sorter_match) begin
               state_next = STATE_RESP;
            end else if (to_cnt == TW'(ACK_TIMEOUT - 1)) begin
               state_next  = STATE_RESP;
               status_next = STAT_TIMEOUT;
            end
         end
         STATE_RESP, STATE_REJECT: state_next = STATE_IDLE;
         default:                  state_next = STATE_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state        <= STATE_IDLE;
         hold_cnt     <= '0;
         to_cnt       <= '0;
         cur_node     <= 1'b0;
         cur_opcode   <= OPC_NOP;
         killed       <= 2'b00;
         out_op_node0 <= '0;
         out_op_node1 <= '0;
         rsp_valid    <= 1'b0;
         rsp_node     <= 1'b0;
         rsp_status   <= STAT_OK;
      end else begin
         state <= state_next;

         if (pop) begin
            cur_node   <= head.node;
            cur_opcode <= head.opcode;
         end

         if (state == STATE_IDLE && state_next == STATE_DRIVE) begin
            hold_cnt     <= HW'(1);
            out_op_node0 <= (head.opcode == OPC_KILL_ALL || !head.node) ? head_word : '0;
            out_op_node1 <= (head.opcode == OPC_KILL_ALL ||  head.node) ? head_word : '0;
         end else if (state_next != STATE_DRIVE) begin
            out_op_node0 <= '0;
            out_op_node1 <= '0;
         end else begin
            hold_cnt <= hold_cnt + 1'b1;
         end

         to_cnt <= (state == STATE_CHECK) ? to_cnt + 1'b1 : '0;

         rsp_valid <= (state_next == STATE_RESP) || (state_next == STATE_REJECT);
         if (state_next == STATE_RESP || state_next == STATE_REJECT) begin
            rsp_status <= status_next;
            rsp_node   <= (state == STATE_IDLE) ? head.node : cur_node;
         end

         // A confirmed kill blocks further commands to that node until reset.
         if (state == STATE_RESP && rsp_status == STAT_OK) begin
            if (cur_opcode == OPC_KILL)     killed[cur_node] <= 1'b1;
            if (cur_opcode == OPC_KILL_ALL) killed           <= 2'b11;
         end
      end
   end

endmodule
